// File: rtl/rom_arbiter_pkg.sv
// Shared constants, FSM encodings and owner type for the boot-ROM arbiter.
// Imported by rom_arb_pick and rom_arbiter.
package rom_arbiter_pkg;

  localparam int ROMBus = 32;
  localparam int ROMAddrBus = 12;
  localparam logic [ROMBus-1:0] ZeroWord = '0;
  localparam logic RstEnable = 1'b0;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbIssue = 2'd1,
    ArbWait  = 2'd2,
    ArbResp  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OwnIf  = 1'b0,
    OwnMem = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational winner selection plus legality check and ROM offset for the
// winning requester. MEM wins unless its streak has hit the cap while IF waits.
module rom_arb_pick
  import rom_arbiter_pkg::*;
#(
  parameter logic [31:0] ROM_BASE       = 32'hBFC00000,
  parameter int          ROM_BYTES      = 4096,
  parameter int          MEM_STREAK_MAX = 4
) (
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [2:0]            streak_i,
  output logic                  any_req_o,
  output arb_owner_e            winner_o,
  output logic                  legal_o,
  output logic [ROMAddrBus-1:0] offset_o
);

  localparam logic [2:0]  STREAK_CAP = 3'(MEM_STREAK_MAX);
  // 33-bit window bounds so a window ending at 4 GiB cannot wrap.
  localparam logic [32:0] WIN_LO = {1'b0, ROM_BASE};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(ROM_BYTES);

  logic        if_wins;
  logic [31:0] sel_addr;
  logic        in_window;

  always_comb begin
    any_req_o = if_req_i || mem_req_i;
    if_wins   = if_req_i && (!mem_req_i || (streak_i == STREAK_CAP));
    winner_o  = if_wins ? OwnIf : OwnMem;
    sel_addr  = if_wins ? if_addr_i : mem_addr_i;
    in_window = ({1'b0, sel_addr} >= WIN_LO) && ({1'b0, sel_addr} < WIN_HI);
    legal_o   = in_window && (sel_addr[1:0] == 2'b00) && (if_wins || !mem_we_i);
    // Low bits of (addr - base) only depend on the low bits of each operand.
    offset_o  = sel_addr[ROMAddrBus-1:0] - ROM_BASE[ROMAddrBus-1:0];
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single-port boot ROM between IF and MEM: pick, chip-enable pulse,
// wait for ROM data (with timeout), then a one-cycle registered response.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter logic [31:0] ROM_BASE       = 32'hBFC00000,
  parameter int          ROM_BYTES      = 4096,
  parameter int          MEM_STREAK_MAX = 4,
  parameter int          TIMEOUT        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  output logic                  if_ack_o,
  output logic [ROMBus-1:0]     if_data_o,
  output logic                  if_err_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [31:0]           mem_addr_i,
  output logic                  mem_ack_o,
  output logic [ROMBus-1:0]     mem_data_o,
  output logic                  mem_err_o,
  output logic                  rom_ce_o,
  output logic                  rom_we_o,
  output logic [ROMAddrBus-1:0] rom_addr_o,
  input  logic [ROMBus-1:0]     rom_data_i,
  input  logic                  rom_ready_i,
  output arb_state_e            dbg_state_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  // Handshake: req/addr/we are levels held by the requester until the cycle
  // after its ack; ack is a single-cycle pulse with err/data valid alongside.
  arb_state_e            state_q;
  arb_owner_e            owner_q;
  logic [2:0]            streak_q, streak_d;
  logic [TMO_W-1:0]      tmo_q;
  logic                  rom_ce_q;
  logic [ROMAddrBus-1:0] rom_addr_q;
  logic                  if_ack_q, if_err_q, mem_ack_q, mem_err_q;
  logic [ROMBus-1:0]     if_data_q, mem_data_q;

  logic                  any_req;
  arb_owner_e            winner;
  logic                  legal;
  logic [ROMAddrBus-1:0] offset;

  rom_arb_pick #(
    .ROM_BASE       (ROM_BASE),
    .ROM_BYTES      (ROM_BYTES),
    .MEM_STREAK_MAX (MEM_STREAK_MAX)
  ) u_pick (
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .mem_req_i  (mem_req_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .streak_i   (streak_q),
    .any_req_o  (any_req),
    .winner_o   (winner),
    .legal_o    (legal),
    .offset_o   (offset)
  );

  always_comb begin
    streak_d = 3'd0;
    if ((winner == OwnMem) && if_req_i) begin
      streak_d = (streak_q == 3'd7) ? streak_q : streak_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_q    <= ArbIdle;
      owner_q    <= OwnIf;
      streak_q   <= 3'd0;
      tmo_q      <= '0;
      rom_ce_q   <= 1'b0;
      rom_addr_q <= '0;
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      if_data_q  <= ZeroWord;
      mem_ack_q  <= 1'b0;
      mem_err_q  <= 1'b0;
      mem_data_q <= ZeroWord;
    end else begin
      case (state_q)
        ArbIdle: begin
          if (any_req) begin
            owner_q  <= winner;
            streak_q <= streak_d;
            if (legal) begin
              rom_ce_q   <= 1'b1;
              rom_addr_q <= offset;
              state_q    <= ArbIssue;
            end else if (winner == OwnIf) begin
              if_ack_q  <= 1'b1;
              if_err_q  <= 1'b1;
              if_data_q <= ZeroWord;
              state_q   <= ArbResp;
            end else begin
              mem_ack_q  <= 1'b1;
              mem_err_q  <= 1'b1;
              mem_data_q <= ZeroWord;
              state_q    <= ArbResp;
            end
          end
        end
        ArbIssue: begin
          rom_ce_q <= 1'b0;
          tmo_q    <= '0;
          state_q  <= ArbWait;
        end
        ArbWait: begin
          if (rom_ready_i || (tmo_q == TMO_LAST)) begin
            // Timeout responses carry err=1 and zero data.
            if (owner_q == OwnIf) begin
              if_ack_q  <= 1'b1;
              if_err_q  <= !rom_ready_i;
              if_data_q <= rom_ready_i ? rom_data_i : ZeroWord;
            end else begin
              mem_ack_q  <= 1'b1;
              mem_err_q  <= !rom_ready_i;
              mem_data_q <= rom_ready_i ? rom_data_i : ZeroWord;
            end
            state_q <= ArbResp;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ArbResp: begin
          if_ack_q  <= 1'b0;
          if_err_q  <= 1'b0;
          mem_ack_q <= 1'b0;
          mem_err_q <= 1'b0;
          state_q   <= ArbIdle;
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_err_o    = if_err_q;
  assign if_data_o   = if_data_q;
  assign mem_ack_o   = mem_ack_q;
  assign mem_err_o   = mem_err_q;
  assign mem_data_o  = mem_data_q;
  assign rom_ce_o    = rom_ce_q;
  assign rom_we_o    = 1'b0;
  assign rom_addr_o  = rom_addr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: single reads, IF starvation guard, illegal
// accesses, ROM timeout and mid-access reset, against a registered-read ROM model.
module tb_rom_arbiter;
  import rom_arbiter_pkg::*;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack, if_err;
  logic [31:0] if_data;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_ack, mem_err;
  logic [31:0] mem_data;
  logic        rom_ce, rom_we;
  logic [11:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic        rom_ready = 1'b0;
  logic        rom_stall = 1'b0;
  arb_state_e  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int ce_cnt = 0;
  int ce_twice = 0;
  logic ce_prev = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] rom_mem [0:1023];

  rom_arbiter #(
    .ROM_BASE(BASE), .ROM_BYTES(4096), .MEM_STREAK_MAX(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack),
    .if_data_o(if_data), .if_err_o(if_err),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_ack_o(mem_ack), .mem_data_o(mem_data), .mem_err_o(mem_err),
    .rom_ce_o(rom_ce), .rom_we_o(rom_we), .rom_addr_o(rom_addr),
    .rom_data_i(rom_data), .rom_ready_i(rom_ready), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- ROM model and ce monitor ----------------
  function automatic logic [31:0] rom_word(input int i);
    return (i == 4) ? 32'h3C08BFC0 : (32'hA5000000 | 32'(i));
  endfunction

  initial for (int i = 0; i < 1024; i++) rom_mem[i] = rom_word(i);

  always @(posedge clk) begin
    rom_ready <= rom_ce && !rom_stall;
    rom_data  <= rom_mem[rom_addr[11:2]];
    ce_prev   <= rom_ce;
    if (rom_ce) ce_cnt <= ce_cnt + 1;
    if (rom_ce && ce_prev) ce_twice <= ce_twice + 1;
  end

  // ---------------- driver / checking tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int max, output int lat);
    lat = -1;
    for (int c = 1; c <= max; c++) begin
      step();
      if (if_ack || mem_ack) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic err_case(input string tag, input logic use_if, input logic we,
                          input logic [31:0] addr);
    int base_ce;
    base_ce = ce_cnt;
    if (use_if) begin if_req = 1'b1; if_addr = addr; end
    else begin mem_req = 1'b1; mem_we = we; mem_addr = addr; end
    step();
    check({tag, "_ack"}, 32'(use_if ? if_ack : mem_ack), 32'd1);
    check({tag, "_err"}, 32'(use_if ? if_err : mem_err), 32'd1);
    check({tag, "_data"}, use_if ? if_data : mem_data, 32'h0);
    check({tag, "_ce"}, 32'(rom_ce), 32'd0);
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    step();
    check({tag, "_ack_drop"}, 32'({if_ack, mem_ack}), 32'd0);
    check({tag, "_idle"}, 32'(dbg_state), 32'(ArbIdle));
    check({tag, "_ce_cnt"}, 32'(ce_cnt), 32'(base_ce));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [31:0] exp_who;

    // Reset values
    repeat (2) step();
    check("rst_outs", {if_ack, if_err, mem_ack, mem_err, rom_ce, rom_we}, 32'd0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_mem_data", mem_data, 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ArbIdle));
    @(negedge clk) rst = 1'b1;
    step();

    // MEM read of word 4: ce in cycle 1, ack in cycle 3
    mem_req = 1'b1; mem_addr = BASE + 32'h10;
    step();
    check("rd_ce1", 32'(rom_ce), 32'd1);
    check("rd_addr", 32'(rom_addr), 32'h010);
    check("rd_we", 32'(rom_we), 32'd0);
    check("rd_ack1", 32'(mem_ack), 32'd0);
    step();
    check("rd_ce2", 32'(rom_ce), 32'd0);
    check("rd_wait", 32'(dbg_state), 32'(ArbWait));
    step();
    check("rd_ack3", {if_ack, mem_ack}, 32'b01);
    check("rd_data", mem_data, 32'h3C08BFC0);
    check("rd_err", 32'(mem_err), 32'd0);
    mem_req = 1'b0;
    step();
    check("rd_ack4", 32'(mem_ack), 32'd0);
    check("rd_idle", 32'(dbg_state), 32'(ArbIdle));

    // Starvation guard: pattern M M M M I repeating
    for (int g = 0; g < 10; g++) exp_q.push_back((g % 5 == 4) ? 32'b10 : 32'b01);
    if_req = 1'b1; if_addr = BASE + 32'h20;
    mem_req = 1'b1; mem_addr = BASE + 32'h10;
    for (int g = 0; g < 10; g++) begin
      wait_ack(12, lat);
      exp_who = exp_q.pop_front();
      check($sformatf("starve_who%0d", g), {30'b0, if_ack, mem_ack}, exp_who);
      check($sformatf("starve_lat%0d", g), 32'(lat), (g == 0) ? 32'd3 : 32'd4);
      if (exp_who == 32'b10) check($sformatf("starve_if_data%0d", g), if_data, rom_word(8));
      else check($sformatf("starve_mem_data%0d", g), mem_data, rom_word(4));
    end
    if_req = 1'b0; mem_req = 1'b0;
    step();

    // Illegal accesses: immediate error, no ROM cycle
    err_case("err_we", 1'b0, 1'b1, BASE + 32'h10);
    err_case("err_oow", 1'b0, 1'b0, BASE + 32'h1000);
    err_case("err_mis", 1'b0, 1'b0, BASE + 32'h2);
    err_case("err_if_low", 1'b1, 1'b0, BASE - 32'h4);

    // Timeout: 8 WAIT cycles, ack in cycle 10
    rom_stall = 1'b1;
    mem_req = 1'b1; mem_addr = BASE + 32'h10;
    wait_ack(20, lat);
    check("to_lat", 32'(lat), 32'd10);
    check("to_err", {mem_ack, mem_err}, 32'b11);
    check("to_data", mem_data, 32'h0);
    mem_req = 1'b0; rom_stall = 1'b0;
    step();
    mem_req = 1'b1; mem_addr = BASE + 32'h24;
    wait_ack(10, lat);
    check("to_fresh_lat", 32'(lat), 32'd3);
    check("to_fresh_err", {mem_ack, mem_err}, 32'b10);
    check("to_fresh_data", mem_data, rom_word(9));
    mem_req = 1'b0;
    step();

    // Reset in WAIT: drop the access, then serve the held request
    mem_req = 1'b1; mem_addr = BASE + 32'h10;
    step(); step();
    check("rw_state", 32'(dbg_state), 32'(ArbWait));
    #2 rst = 1'b0;
    #1;
    check("rw_outs", {if_ack, if_err, mem_ack, mem_err, rom_ce}, 32'd0);
    check("rw_mem_data", mem_data, 32'h0);
    check("rw_if_data", if_data, 32'h0);
    check("rw_rom_addr", 32'(rom_addr), 32'h0);
    check("rw_state0", 32'(dbg_state), 32'(ArbIdle));
    step();
    check("rw_noack", 32'(mem_ack), 32'd0);
    @(negedge clk) rst = 1'b1;
    wait_ack(10, lat);
    check("rw_lat", 32'(lat), 32'd3);
    check("rw_data", mem_data, 32'h3C08BFC0);
    mem_req = 1'b0;
    step();

    check("ce_never_twice", 32'(ce_twice), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
